// File: rtl/add_reduce_pkg.sv
// Shared types and elaboration-time helpers for the add_reduce reducer.
package add_reduce_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } add_reduce_state_t;

  function automatic int unsigned sum_w(input int unsigned n_ops, input int unsigned in_w);
    return in_w + $clog2(n_ops);
  endfunction

  // Number of RUN steps needed to fold n_ops live values down to one.
  function automatic int unsigned reduce_cycles(input int unsigned n_ops, input int unsigned n_add);
    int unsigned m;
    int unsigned p;
    int unsigned c;
    m = n_ops;
    c = 0;
    if (n_add == 0) return 0;
    while (m > 1) begin
      p = (m / 2 < n_add) ? m / 2 : n_add;
      m = m - p;
      c++;
    end
    return c;
  endfunction

endpackage

// File: rtl/add_reduce_step.sv
// One combinational reduction step: N_ADD pairwise adders followed by compaction
// of the untouched tail down to just above the new sums.
module add_reduce_step #(
  parameter int unsigned N_OPS = 7,
  parameter int unsigned N_ADD = 2,
  parameter int unsigned SUM_W = 16,
  parameter int unsigned M_W   = 3
) (
  input  logic [N_OPS-1:0][SUM_W-1:0] i_v,
  input  logic [M_W-1:0]              i_m,
  output logic [N_OPS-1:0][SUM_W-1:0] o_v,
  output logic [M_W-1:0]              o_m
);

  // Zero padding keeps every shifted/paired read in range for any live count.
  logic [2*N_OPS-1:0][SUM_W-1:0] w_ext;
  int unsigned                   w_m;
  int unsigned                   w_p;

  always_comb begin
    w_ext            = '0;
    w_ext[N_OPS-1:0] = i_v;
    w_m              = 32'(i_m);
    w_p              = (w_m / 2 < N_ADD) ? w_m / 2 : N_ADD;
    o_v              = i_v;
    for (int unsigned k = 0; k < N_OPS; k++) begin
      if (k >= w_p && k < w_m - w_p) o_v[k] = w_ext[k + w_p];
    end
    for (int unsigned i = 0; i < N_ADD; i++) begin
      if (i < w_p) o_v[i] = w_ext[2 * i] + w_ext[2 * i + 1];
    end
    o_m = M_W'(w_m - w_p);
  end

endmodule

// File: rtl/add_reduce.sv
// Multi-operand adder reducer on N_ADD shared adders with sticky done flag.
// Build option ADD_REDUCE_SAT_EN: saturate result to OUT_W bits instead of wrapping.
module add_reduce
  import add_reduce_pkg::*;
#(
  parameter int unsigned N_OPS = 7,
  parameter int unsigned IN_W  = 13,
  parameter int unsigned N_ADD = 2,
  parameter int unsigned OUT_W = IN_W + $clog2(N_OPS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   r_enable,
  input  logic [N_OPS*IN_W-1:0]  init_ops,
  output logic                   busy,
  output logic                   w_enable,
  output logic [OUT_W-1:0]       result,
  output logic                   sat
);

  localparam int unsigned SUM_W   = sum_w(N_OPS, IN_W);
  localparam int unsigned M_W     = $clog2(N_OPS + 1);
  localparam int unsigned N_STEPS = reduce_cycles(N_OPS, N_ADD);

  add_reduce_state_t             r_state;
  logic [N_OPS-1:0][SUM_W-1:0]   r_v;
  logic [M_W-1:0]                r_m;
  logic [M_W-1:0]                r_steps;
  logic                          r_busy;
  logic                          r_wen;
  logic [OUT_W-1:0]              r_result;
  logic                          r_sat;

  logic [N_OPS-1:0][SUM_W-1:0]   w_v;
  logic [M_W-1:0]                w_m;
  logic [OUT_W-1:0]              w_res;
  logic                          w_sat;

  add_reduce_step #(
    .N_OPS (N_OPS),
    .N_ADD (N_ADD),
    .SUM_W (SUM_W),
    .M_W   (M_W)
  ) u_step (
    .i_v (r_v),
    .i_m (r_m),
    .o_v (w_v),
    .o_m (w_m)
  );

`ifdef ADD_REDUCE_SAT_EN
  localparam logic [SUM_W-1:0] OUT_MAX = SUM_W'({OUT_W{1'b1}});
  assign w_sat = (r_v[0] > OUT_MAX);
  assign w_res = w_sat ? '1 : r_v[0][OUT_W-1:0];
`else
  assign w_sat = 1'b0;
  assign w_res = r_v[0][OUT_W-1:0];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_v      <= '0;
      r_m      <= '0;
      r_steps  <= '0;
      r_busy   <= 1'b0;
      r_wen    <= 1'b0;
      r_result <= '0;
      r_sat    <= 1'b0;
    end else if (r_enable) begin
      for (int unsigned i = 0; i < N_OPS; i++) begin
        r_v[i] <= SUM_W'(init_ops[i*IN_W +: IN_W]);
      end
      r_m     <= M_W'(N_OPS);
      r_steps <= '0;
      r_state <= RUN;
      r_busy  <= 1'b1;
      r_wen   <= 1'b0;
      r_sat   <= 1'b0;
    end else begin
      case (r_state)
        RUN: begin
          if (r_m > M_W'(1)) begin
            r_v     <= w_v;
            r_m     <= w_m;
            r_steps <= r_steps + M_W'(1);
          end else begin
            assert (32'(r_steps) == N_STEPS);
            r_state  <= DONE;
            r_busy   <= 1'b0;
            r_wen    <= 1'b1;
            r_result <= w_res;
            r_sat    <= w_sat;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy     = r_busy;
  assign w_enable = r_wen;
  assign result   = r_result;
  assign sat      = r_sat;

endmodule

// File: tb/tb_add_reduce.sv
// Randomised/directed bench for add_reduce across four parameterisations sharing one stimulus.
module tb_add_reduce;
  import add_reduce_pkg::*;

  localparam int unsigned NO   = 7;
  localparam int unsigned IW   = 13;
  localparam int unsigned ND   = 4;
  localparam int unsigned KMAX = 9;

  logic            clk = 1'b0;
  logic            rst;
  logic            r_enable;
  logic [NO*IW-1:0] init_ops;
  logic            busy_o [ND];
  logic            wen_o  [ND];
  logic            sat_o  [ND];
  logic [15:0]     res_o  [ND];
  logic [12:0]     res13;

  int unsigned total = 0;
  int unsigned bad   = 0;
  // Completion latency (strobe edge to w_enable edge) per instance: N_ADD = 2, 1, 6, 2.
  int unsigned lat [ND] = '{5, 7, 4, 5};
  logic [15:0] prev_res [ND];
  int unsigned ops [NO];

  always #5 clk = ~clk;

  add_reduce dut0 (
    .clk(clk), .rst(rst), .r_enable(r_enable), .init_ops(init_ops),
    .busy(busy_o[0]), .w_enable(wen_o[0]), .result(res_o[0]), .sat(sat_o[0])
  );
  add_reduce #(.N_ADD(1)) dut1 (
    .clk(clk), .rst(rst), .r_enable(r_enable), .init_ops(init_ops),
    .busy(busy_o[1]), .w_enable(wen_o[1]), .result(res_o[1]), .sat(sat_o[1])
  );
  add_reduce #(.N_ADD(6)) dut2 (
    .clk(clk), .rst(rst), .r_enable(r_enable), .init_ops(init_ops),
    .busy(busy_o[2]), .w_enable(wen_o[2]), .result(res_o[2]), .sat(sat_o[2])
  );
  add_reduce #(.OUT_W(13)) dut3 (
    .clk(clk), .rst(rst), .r_enable(r_enable), .init_ops(init_ops),
    .busy(busy_o[3]), .w_enable(wen_o[3]), .result(res13), .sat(sat_o[3])
  );
  assign res_o[3] = {3'b000, res13};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_res(input int unsigned d, input int unsigned s);
    if (d != 3) return 16'(s);
`ifdef ADD_REDUCE_SAT_EN
    return (s > 8191) ? 16'd8191 : 16'(s);
`else
    return 16'(s % 8192);
`endif
  endfunction

  function automatic logic exp_sat(input int unsigned d, input int unsigned s);
`ifdef ADD_REDUCE_SAT_EN
    return (d == 3) && (s > 8191);
`else
    return (d == 3) && (s > 8191) && 1'b0;
`endif
  endfunction

  task automatic load_ops();
    init_ops = '0;
    for (int unsigned i = 0; i < NO; i++) init_ops[i*IW +: IW] = IW'(ops[i]);
  endtask

  // Drive one strobe edge; returns at the negedge after it with garbage on init_ops.
  task automatic strobe();
    load_ops();
    r_enable = 1'b1;
    @(posedge clk);
    @(negedge clk);
    r_enable = 1'b0;
    for (int unsigned i = 0; i < NO; i++) init_ops[i*IW +: IW] = IW'($urandom);
  endtask

  task automatic chk_idle(input string name);
    for (int unsigned d = 0; d < ND; d++) begin
      chk($sformatf("%s_busy%0d", name, d), 32'(busy_o[d]), 32'd0);
      chk($sformatf("%s_wen%0d",  name, d), 32'(wen_o[d]),  32'd0);
      chk($sformatf("%s_res%0d",  name, d), 32'(res_o[d]),  32'd0);
      chk($sformatf("%s_sat%0d",  name, d), 32'(sat_o[d]),  32'd0);
    end
    chk($sformatf("%s_state", name), 32'(dut0.r_state), 32'(IDLE));
  endtask

  task automatic chk_inflight(input string name);
    for (int unsigned d = 0; d < ND; d++) begin
      chk($sformatf("%s_busy%0d", name, d), 32'(busy_o[d]), 32'd1);
      chk($sformatf("%s_wen%0d",  name, d), 32'(wen_o[d]),  32'd0);
      chk($sformatf("%s_res%0d",  name, d), 32'(res_o[d]),  32'(prev_res[d]));
    end
  endtask

  // Called at the negedge after the strobe edge (k = 0); walks k = 0..KMAX.
  task automatic check_run(input string name);
    int unsigned s;
    logic        done_e;
    s = 0;
    for (int unsigned i = 0; i < NO; i++) s += ops[i];
    for (int unsigned k = 0; k <= KMAX; k++) begin
      for (int unsigned d = 0; d < ND; d++) begin
        done_e = (k >= lat[d]);
        chk($sformatf("%s_k%0d_busy%0d", name, k, d), 32'(busy_o[d]), 32'(!done_e));
        chk($sformatf("%s_k%0d_wen%0d",  name, k, d), 32'(wen_o[d]),  32'(done_e));
        chk($sformatf("%s_k%0d_res%0d",  name, k, d), 32'(res_o[d]),
            32'(done_e ? exp_res(d, s) : prev_res[d]));
        chk($sformatf("%s_k%0d_sat%0d",  name, k, d), 32'(sat_o[d]),
            32'(done_e ? exp_sat(d, s) : 1'b0));
      end
      if (k < KMAX) @(negedge clk);
    end
    for (int unsigned d = 0; d < ND; d++) prev_res[d] = exp_res(d, s);
  endtask

  initial begin
    rst      = 1'b1;
    r_enable = 1'b0;
    init_ops = '0;
    for (int unsigned d = 0; d < ND; d++) prev_res[d] = '0;

    repeat (3) @(negedge clk);
    chk_idle("reset");
    chk("reset_m", 32'(dut0.r_m), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk_idle("post_reset");

    chk("cyc_add2", reduce_cycles(7, 2), 32'd4);
    chk("cyc_add1", reduce_cycles(7, 1), 32'd6);
    chk("cyc_add3", reduce_cycles(7, 3), 32'd3);

    for (int unsigned i = 0; i < NO; i++) ops[i] = i + 1;
    strobe();
    check_run("seq");

    for (int unsigned i = 0; i < NO; i++) ops[i] = 8191;
    strobe();
    check_run("allmax");

    for (int unsigned i = 0; i < NO; i++) ops[i] = 0;
    ops[3] = 8191;
    strobe();
    check_run("edge8191");

    ops[0] = 1;
    strobe();
    check_run("edge8192");

    for (int unsigned t = 0; t < 6; t++) begin
      for (int unsigned i = 0; i < NO; i++) ops[i] = $urandom_range(0, 8191);
      strobe();
      check_run($sformatf("rand%0d", t));
    end

    // Restart two edges into a reduction; the first sum must never surface.
    for (int unsigned i = 0; i < NO; i++) ops[i] = i + 1;
    strobe();
    chk_inflight("rs_k0");
    @(negedge clk);
    chk_inflight("rs_k1");
    for (int unsigned i = 0; i < NO; i++) ops[i] = 1;
    strobe();
    check_run("restart");

    // Strobe held for three edges with changing operands; only the last set counts.
    for (int unsigned h = 0; h < 2; h++) begin
      for (int unsigned i = 0; i < NO; i++) ops[i] = $urandom_range(0, 8191);
      load_ops();
      r_enable = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk_inflight($sformatf("hold%0d", h));
    end
    for (int unsigned i = 0; i < NO; i++) ops[i] = $urandom_range(0, 8191);
    strobe();
    check_run("held");

    // Reset wins over a simultaneous strobe mid-run.
    for (int unsigned i = 0; i < NO; i++) ops[i] = $urandom_range(0, 8191);
    strobe();
    @(negedge clk);
    @(negedge clk);
    rst      = 1'b1;
    r_enable = 1'b1;
    for (int unsigned i = 0; i < NO; i++) ops[i] = $urandom_range(0, 8191);
    load_ops();
    @(negedge clk);
    chk_idle("rst_mid");
    rst      = 1'b0;
    r_enable = 1'b0;
    for (int unsigned d = 0; d < ND; d++) prev_res[d] = '0;
    @(negedge clk);
    chk_idle("rst_after");
    for (int unsigned i = 0; i < NO; i++) ops[i] = $urandom_range(0, 8191);
    strobe();
    check_run("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
